acc_sequencer: RTL
==================

# acc_sequencer

- Sequences a signed W-bit accumulate datapath over a programmed-length burst of streaming samples and returns one result per command.
- Covers load on the first sample, add on the rest, and an optional final absolute value.
- Sits between the sample stream feeding the DSP chain and the downstream consumer of block sums: energy, L1-norm and DC-estimate stages.
- Owns the accumulator register and its control; no other block drives it.

## Interface
- `W`, 32: sample/result width, signed two's complement.
- `LEN_W`, 8: width of burst length field; max burst 2^LEN_W − 1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  in  1  command strobe; accepted only in IDLE.
- `len`  in  LEN_W  samples in burst; captured with `start`.
- `abs_mode`  in  1  apply absolute value to final sum; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `s_data`  in  W  signed sample.
- `r_valid`  out  1  result valid; held until accepted.
- `r_ready`  in  1  consumer accepts when `r_valid && r_ready`.
- `r_data`  out  W  result; stable while `r_valid` is high.

## Operation
- States: IDLE, FIRST, ACCUM, ABS, DONE.
- IDLE:
  - `start` captures `len` and `abs_mode`.
  - If `len`==0, go to DONE with `r_data`=0. Otherwise go to FIRST.
- FIRST:
  - `s_ready`=1. On a handshake, load acc←`s_data` and set count=1.
  - If `len`==1, go to ABS when `abs_mode`, else DONE. Otherwise go to ACCUM.
- ACCUM:
  - `s_ready`=1. On a handshake, acc←acc+`s_data` and count++.
  - When the handshake completes count==`len`, go to ABS or DONE.
  - No handshake means hold.
- ABS: if acc[W-1], acc←−acc; otherwise hold. One cycle, then DONE. `s_ready`=0.
- DONE: `r_valid`=1 and `r_data`=acc. On `r_ready`, go to IDLE. `s_ready`=0.
- Arithmetic is modulo 2^W: wrap on overflow. −(−2^(W-1)) = −2^(W-1).
- `start` outside IDLE is ignored; it is not queued.
- `len`/`abs_mode` changes after capture have no effect.
- Samples offered while `s_ready`=0 are not consumed.
- Reset, including mid-burst:
  - Next cycle is IDLE with acc=0 and count=0.
  - `busy`=0, `s_ready`=0, `r_valid`=0, `r_data`=0.
  - Any in-flight result is discarded.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- `start` accepted at edge t0 → FIRST in cycle t0+1, so `s_ready` is high that cycle.
- With `s_valid` held high, samples are consumed at edges t1…tN.
- `r_valid` rises in the cycle after edge tN without ABS; one cycle later with ABS.
- Total latency from start to result: N+1 cycles, or N+2 with ABS.
- `len`=0: `r_valid` in cycle t0+1.
- DONE→IDLE on the `r_ready` edge. The earliest new `start` is accepted at the following edge; there is no same-cycle restart.
- Throughput: one sample per cycle. `s_valid` gaps only stall the burst.

## Configuration
- `ACC_SEQ_SAT_EN` defined:
  - The ACCUM add saturates: positive overflow → 2^(W-1)−1, negative overflow → −2^(W-1).
  - ABS of −2^(W-1) yields 2^(W-1)−1.
  - Adds one compare stage in the add path; cycle timing is unchanged.
- Undefined: plain wrap-around add and negate as in Operation.

## Structure
- Package `acc_seq_pkg` holds:
  - the state enum typedef (IDLE, FIRST, ACCUM, ABS, DONE);
  - localparams for saturation bounds derived from `W`.
- Sub-module `acc_seq_core` holds the acc register with load/add/abs/clear controls and the optional saturation logic.
- Top level holds the FSM, length counter and handshakes.

## Test plan
- W=32, `len`=4, `abs_mode`=0, samples 5, −3, 10, 1 back-to-back → `r_data`=13. `r_valid` in cycle t0+5, held until `r_ready`.
- `len`=3, `abs_mode`=1, samples −7, −8, 2 → `r_data`=13, `r_valid` in cycle t0+5. Repeat with `s_valid` low on alternate cycles → same result, 3 stall cycles later.
- `len`=0 → `r_data`=0, `r_valid` in t0+1. `start` pulsed during a burst and during DONE → ignored, one result only.
- Samples 0x7FFFFFFF, 1 with `len`=2: without macro → 0x80000000; with `ACC_SEQ_SAT_EN` → 0x7FFFFFFF. `len`=1, sample 0x80000000, `abs_mode`=1: without macro → 0x80000000; with macro → 0x7FFFFFFF.
- `reset` asserted after 2 of 4 samples → next cycle `busy`=0, `s_ready`=0, `r_valid`=0. A new `len`=1 burst with sample 9 → `r_data`=9, no residue.
- `r_ready` held low 10 cycles in DONE → `r_valid` and `r_data` stable, `s_ready`=0 throughout.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared types and constants for the accumulate sequencer.
//   state_e         - sequencer FSM states
//   AccW / LenW     - default sample and burst-length widths
//   AccMax / AccMin - saturation bounds for the default sample width
package acc_seq_pkg;

  localparam int unsigned AccW = 32;
  localparam int unsigned LenW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,
    StAccum,
    StAbs,
    StDone
  } state_e;

  localparam logic [AccW-1:0] AccMax = {1'b0, {(AccW-1){1'b1}}};
  localparam logic [AccW-1:0] AccMin = {1'b1, {(AccW-1){1'b0}}};

endpackage

// File: rtl/acc_seq_if.sv
// acc_seq_if: command, sample-stream and result-stream signals of acc_sequencer.
//   start/len/abs_mode/busy     - command port
//   s_valid/s_ready/s_data      - sample stream into the sequencer
//   r_valid/r_ready/r_data      - result stream out of the sequencer
// Modports: slave = sequencer side, master = producer/consumer side.
interface acc_seq_if
  import acc_seq_pkg::*;
#(
  parameter int unsigned W     = AccW,
  parameter int unsigned LEN_W = LenW
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             abs_mode;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             r_valid;
  logic             r_ready;
  logic [W-1:0]     r_data;

  modport slave (
    input  start, len, abs_mode, s_valid, s_data, r_ready,
    output busy, s_ready, r_valid, r_data
  );

  modport master (
    output start, len, abs_mode, s_valid, s_data, r_ready,
    input  busy, s_ready, r_valid, r_data
  );

endinterface

// File: rtl/acc_seq_core.sv
// acc_seq_core: the accumulator register and its datapath.
//   clk, reset - clock and synchronous active-high reset
//   clear      - acc <= 0
//   load       - acc <= din
//   add        - acc <= acc + din
//   do_abs     - acc <= |acc|
//   din        - signed sample
//   acc        - current accumulator value
// Controls are prioritised clear > load > add > do_abs; the sequencer only
// ever raises one at a time.
// ACC_SEQ_SAT_EN: when defined the add and the negate saturate instead of
// wrapping.
module acc_seq_core
  import acc_seq_pkg::*;
#(
  parameter int unsigned W = AccW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         add,
  input  logic         do_abs,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

`ifdef ACC_SEQ_SAT_EN
  localparam logic [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};
`endif

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] sum;
  logic [W-1:0] neg;

  always_comb begin
    sum = acc_q + din;
    neg = -acc_q;
`ifdef ACC_SEQ_SAT_EN
    // Overflow only when both operands share a sign the result lost.
    if ((acc_q[W-1] == din[W-1]) && (sum[W-1] != acc_q[W-1])) begin
      sum = acc_q[W-1] ? SatMin : SatMax;
    end
    if (acc_q == SatMin) begin
      neg = SatMax;
    end
`endif
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = din;
    end else if (add) begin
      acc_d = sum;
    end else if (do_abs && acc_q[W-1]) begin
      acc_d = neg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: runs one accumulate burst per command and returns its sum.
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - acc_seq_if.slave: command (start/len/abs_mode/busy), sample
//           stream (s_*) and result stream (r_*)
// A command loads the first sample, adds the remaining len-1, optionally
// takes the absolute value, then holds the result until it is accepted.
// ACC_SEQ_SAT_EN: when defined the accumulate and absolute value saturate
// (handled inside acc_seq_core).
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned W     = AccW,
  parameter int unsigned LEN_W = LenW
) (
  input  logic       clk,
  input  logic       reset,
  acc_seq_if.slave   bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic             abs_q, abs_d;

  logic             s_ready;
  logic             hs;
  logic             acc_clear, acc_load, acc_add, acc_abs;
  logic [W-1:0]     acc;

  assign s_ready   = (state_q == StFirst) || (state_q == StAccum);
  assign hs        = bus.s_valid && s_ready;
  assign count_inc = count_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    abs_d     = abs_q;
    count_d   = count_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    acc_abs   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d     = bus.len;
          abs_d     = bus.abs_mode;
          count_d   = '0;
          // Cleared so an empty burst reports zero.
          acc_clear = 1'b1;
          state_d   = (bus.len == '0) ? StDone : StFirst;
        end
      end
      StFirst: begin
        if (hs) begin
          acc_load = 1'b1;
          count_d  = LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = abs_q ? StAbs : StDone;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (hs) begin
          acc_add = 1'b1;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = abs_q ? StAbs : StDone;
          end
        end
      end
      StAbs: begin
        acc_abs = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (bus.r_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
      abs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      abs_q   <= abs_d;
    end
  end

  acc_seq_core #(
    .W (W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .load   (acc_load),
    .add    (acc_add),
    .do_abs (acc_abs),
    .din    (bus.s_data),
    .acc    (acc)
  );

  assign bus.busy    = (state_q != StIdle);
  assign bus.s_ready = s_ready;
  assign bus.r_valid = (state_q == StDone);
  // Gated so the result port reads zero outside DONE.
  assign bus.r_data  = (state_q == StDone) ? acc : '0;

endmodule
